// File: rtl/wb_commit_pkg.sv
// rtl/wb_commit_pkg.sv - shared defines and package for the wb_commit write-back stage
`ifndef WB_COMMIT_DEFINES
`define WB_COMMIT_DEFINES
`define Reg           32
`define Reg_Addr      5
`define Reg_Num       32
`define Zero_Word     32'h0000_0000
`define Reg_Zero      5'b00000
`define Write_Enable  1'b1
`define Write_Disable 1'b0
`define Read_Enable   1'b1
`define Read_Disable  1'b0
`define Rst_Enable    1'b1
`endif

package wb_commit_pkg;
  localparam int DATA_W  = `Reg;
  localparam int ADDR_W  = `Reg_Addr;
  localparam int REG_NUM = `Reg_Num;
  localparam int CNT_W   = 32;

  // A write from the stage being retired this cycle satisfies a read of the same register.
  function automatic logic addr_hit(input logic                 wreg,
                                    input logic [ADDR_W-1:0]    waddr,
                                    input logic [ADDR_W-1:0]    raddr);
    return (wreg == `Write_Enable) && (waddr == raddr);
  endfunction
endpackage

// File: rtl/wb_commit_regfile_2r1w.sv
// rtl/wb_commit_regfile_2r1w.sv - 32-entry GPR array with r0 masking and two write-first read ports
module regfile_2r1w
  import wb_commit_pkg::*;
#(
  parameter int DATA_W_P  = DATA_W,
  parameter int ADDR_W_P  = ADDR_W,
  parameter int REG_NUM_P = REG_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W_P-1:0] waddr,
  input  logic [DATA_W_P-1:0] wdata,
  input  logic                re1,
  input  logic [ADDR_W_P-1:0] raddr1,
  output logic [DATA_W_P-1:0] rdata1,
  input  logic                re2,
  input  logic [ADDR_W_P-1:0] raddr2,
  output logic [DATA_W_P-1:0] rdata2
);

  logic [DATA_W_P-1:0] gpr [REG_NUM_P];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `Rst_Enable) begin
      for (int i = 0; i < REG_NUM_P; i++) begin
        gpr[i] <= '0;
      end
    end else if ((we == `Write_Enable) && (waddr != '0)) begin
      gpr[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst == `Rst_Enable) begin
      rdata1 = '0;
    end else if (re1 == `Read_Disable) begin
      rdata1 = '0;
    end else if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (addr_hit(we, waddr, raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = gpr[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst == `Rst_Enable) begin
      rdata2 = '0;
    end else if (re2 == `Read_Disable) begin
      rdata2 = '0;
    end else if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (addr_hit(we, waddr, raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = gpr[raddr2];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - write-back commit stage: GPRs, HI/LO, LL bit; WB_COMMIT_CNT_EN adds commit_cnt
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              wb_llbit_we,
  input  logic              wb_llbit_value,
  input  logic              flush,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              llbit_o
`ifdef WB_COMMIT_CNT_EN
  ,
  output logic [CNT_W-1:0]  commit_cnt
`endif
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              llbit_q;
  logic              llbit_d;

  regfile_2r1w u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // No HI/LO bypass: EX already forwards from MEM/WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == `Rst_Enable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo == `Write_Enable) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // Flush beats a same-cycle SC/LL update so a trapped LL never leaves the link set.
  always_comb begin
    llbit_d = llbit_q;
    if (flush) begin
      llbit_d = 1'b0;
    end else if (wb_llbit_we == `Write_Enable) begin
      llbit_d = wb_llbit_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `Rst_Enable) begin
      llbit_q <= 1'b0;
    end else begin
      llbit_q <= llbit_d;
    end
  end

  assign llbit_o = (rst == `Rst_Enable) ? 1'b0 : llbit_d;

`ifdef WB_COMMIT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst == `Rst_Enable) begin
      commit_cnt <= '0;
    end else if ((wb_wreg == `Write_Enable) && (wb_wd != `Reg_Zero)) begin
      commit_cnt <= commit_cnt + 1'b1;
    end
  end
`endif

endmodule
